// File: rtl/lcm_report_buffer.sv
// LCM-side frame buffer: stores whole report/config frames, then hands each
// committed frame to the 2:1 NIC mux over a req/ack handshake as one burst.
module lcm_report_buffer #(
  parameter int unsigned AW            = 8,
  parameter int unsigned MAX_PKT_WORDS = 128,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [133:0]     iv_data,
  input  logic             i_data_wr,
  output logic             o_data_lcm_req,
  input  logic             i_data_lcm_ack,
  output logic [133:0]     ov_data_lcm,
  output logic [AW:0]      ov_frame_cnt,
  output logic             o_drop_pulse,
  output logic [CNT_W-1:0] ov_drop_cnt
);

  localparam int unsigned DW    = 134;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;

  localparam logic [1:0]    TYP_HEAD = 2'b01;
  localparam logic [1:0]    TYP_TAIL = 2'b10;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND, R_GAP} r_state_t;

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;

  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] commit_ptr, commit_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] len, len_nxt;
  logic [PW-1:0] free_rb;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;

  logic          is_head, is_tail, in_word, head_fits;
  logic          drop_c, commit_c, tail_rd_c;
  logic          req_nxt;
  logic [DW-1:0] data_nxt;

  assign is_head = i_data_wr && (iv_data[133:132] == TYP_HEAD);
  assign is_tail = i_data_wr && (iv_data[133:132] == TYP_TAIL);
  assign in_word = i_data_wr && !is_head;

  // Space is judged after discarding any open frame; outside W_FRAME wr_ptr == commit_ptr.
  assign free_rb   = DEPTH_P - (commit_ptr - rd_ptr);
  assign head_fits = (free_rb >= MAX_P);

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_addr] <= iv_data;
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Write FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state    <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
    end else begin
      w_state    <= w_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      len        <= len_nxt;
    end
  end

  // Write FSM next state: accept, roll back or discard incoming words
  always_comb begin
    w_nxt      = w_state;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    len_nxt    = len;
    mem_we     = 1'b0;
    mem_addr   = wr_ptr[AW-1:0];
    drop_c     = 1'b0;
    commit_c   = 1'b0;
    if (is_head) begin
      drop_c = (w_state == W_FRAME);
      if (head_fits) begin
        mem_we     = 1'b1;
        mem_addr   = commit_ptr[AW-1:0];
        wr_ptr_nxt = commit_ptr + PW'(1);
        len_nxt    = PW'(1);
        w_nxt      = W_FRAME;
      end else begin
        drop_c     = 1'b1;
        wr_ptr_nxt = commit_ptr;
        w_nxt      = W_DROP;
      end
    end else if (in_word) begin
      unique case (w_state)
        W_FRAME: begin
          if (len >= MAX_P) begin
            drop_c     = 1'b1;
            wr_ptr_nxt = commit_ptr;
            w_nxt      = is_tail ? W_IDLE : W_DROP;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            len_nxt    = len + PW'(1);
            if (is_tail) begin
              commit_nxt = wr_ptr + PW'(1);
              commit_c   = 1'b1;
              w_nxt      = W_IDLE;
            end
          end
        end
        W_DROP: if (is_tail) w_nxt = W_IDLE;
        default: ;
      endcase
    end
  end

  // Read FSM state register and registered mux-side outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= R_IDLE;
      rd_ptr         <= '0;
      o_data_lcm_req <= 1'b0;
      ov_data_lcm    <= '0;
    end else begin
      r_state        <= r_nxt;
      rd_ptr         <= rd_ptr_nxt;
      o_data_lcm_req <= req_nxt;
      ov_data_lcm    <= data_nxt;
    end
  end

  // Read FSM next state: request, stream one committed frame, then idle one edge
  always_comb begin
    r_nxt      = r_state;
    rd_ptr_nxt = rd_ptr;
    req_nxt    = o_data_lcm_req;
    data_nxt   = ov_data_lcm;
    tail_rd_c  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ov_frame_cnt != '0) begin
          req_nxt = 1'b1;
          r_nxt   = R_REQ;
        end
      end
      R_REQ: begin
        if (i_data_lcm_ack) begin
          req_nxt    = 1'b0;
          data_nxt   = rd_word;
          rd_ptr_nxt = rd_ptr + PW'(1);
          tail_rd_c  = (rd_word[133:132] == TYP_TAIL);
          r_nxt      = tail_rd_c ? R_GAP : R_SEND;
        end
      end
      R_SEND: begin
        data_nxt   = rd_word;
        rd_ptr_nxt = rd_ptr + PW'(1);
        tail_rd_c  = (rd_word[133:132] == TYP_TAIL);
        if (tail_rd_c) r_nxt = R_GAP;
      end
      R_GAP: begin
        data_nxt = '0;
        r_nxt    = R_IDLE;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  // Frame count and drop statistics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_frame_cnt <= '0;
      o_drop_pulse <= 1'b0;
      ov_drop_cnt  <= '0;
    end else begin
      if (commit_c && !tail_rd_c) begin
        ov_frame_cnt <= ov_frame_cnt + PW'(1);
      end else if (!commit_c && tail_rd_c) begin
        ov_frame_cnt <= ov_frame_cnt - PW'(1);
      end
      o_drop_pulse <= drop_c;
      if (drop_c && !(&ov_drop_cnt)) ov_drop_cnt <= ov_drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lcm_report_buffer.sv
// Bench for lcm_report_buffer: queue-based frame model plus a small mux
// model with programmable ack delay and stray acks.
module tb_lcm_report_buffer;

  localparam int unsigned AW    = 8;
  localparam int unsigned MAXW  = 128;
  localparam int unsigned CNT_W = 16;
  localparam int          DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [133:0]     iv_data = '0;
  logic             data_wr = 1'b0;
  logic             req;
  logic             ack = 1'b0;
  logic [133:0]     ov_data;
  logic [AW:0]      frame_cnt;
  logic             drop_pulse;
  logic [CNT_W-1:0] drop_cnt;

  lcm_report_buffer #(.AW(AW), .MAX_PKT_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .iv_data        (iv_data),
    .i_data_wr      (data_wr),
    .o_data_lcm_req (req),
    .i_data_lcm_ack (ack),
    .ov_data_lcm    (ov_data),
    .ov_frame_cnt   (frame_cnt),
    .o_drop_pulse   (drop_pulse),
    .ov_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame model: stored committed words in arrival order, plus the open frame
  logic [133:0] committed[$];
  logic [133:0] partial[$];
  int           m_state;      // 0 idle, 1 collecting a frame, 2 discarding
  int           m_frames;
  int           m_drops;
  logic         m_drop_now;

  function automatic void model_reset();
    committed.delete();
    partial.delete();
    m_state = 0; m_frames = 0; m_drops = 0; m_drop_now = 1'b0;
  endfunction

  function automatic void note_drop();
    m_drop_now = 1'b1;
  endfunction

  function automatic void model_write(input logic wr, input logic [133:0] d);
    int free;
    m_drop_now = 1'b0;
    if (wr) begin
      if (d[133:132] == 2'b01) begin
        if (m_state == 1) begin
          partial.delete();
          note_drop();
        end
        free = DEPTH - committed.size();
        if (free >= MAXW) begin
          partial.push_back(d);
          m_state = 1;
        end else begin
          note_drop();
          m_state = 2;
        end
      end else if (m_state == 1) begin
        if (partial.size() + 1 > MAXW) begin
          partial.delete();
          note_drop();
          m_state = (d[133:132] == 2'b10) ? 0 : 2;
        end else begin
          partial.push_back(d);
          if (d[133:132] == 2'b10) begin
            foreach (partial[i]) committed.push_back(partial[i]);
            partial.delete();
            m_frames++;
            m_state = 0;
          end
        end
      end else if (m_state == 2 && d[133:132] == 2'b10) begin
        m_state = 0;
      end
    end
    if (m_drop_now && m_drops < 65535) m_drops++;
  endfunction

  // Mux model
  typedef enum int {P_IDLE, P_REQ, P_SEND, P_GAP} phase_t;
  phase_t phase = P_IDLE;
  int     ack_wait = 0;
  int     dly_min = 0, dly_max = 0;
  bit     mux_en = 1'b1;
  bit     spur = 1'b0;
  logic   ack_next = 1'b0;

  task automatic expect_word();
    logic [133:0] exp;
    check("out_avail", 134'(committed.size() != 0), 134'(1));
    if (committed.size() != 0) begin
      exp = committed.pop_front();
      check("out_word", ov_data, exp);
      if (exp[133:132] == 2'b10) begin
        m_frames--;
        phase = P_GAP;
      end else begin
        phase = P_SEND;
      end
    end
  endtask

  task automatic step(input logic wr, input logic [133:0] d);
    int   cnt_prev;
    logic acked;
    data_wr = wr;
    iv_data = d;
    ack     = ack_next;
    acked   = ack_next;
    @(posedge clk);
    #1;
    cnt_prev = m_frames;
    model_write(wr, d);
    case (phase)
      P_IDLE: begin
        check("req_idle", 134'(req), 134'(cnt_prev > 0));
        check("data_idle", ov_data, '0);
        if (req) begin
          phase    = P_REQ;
          ack_wait = $urandom_range(dly_max, dly_min);
        end
      end
      P_REQ: begin
        if (acked) begin
          check("req_after_ack", 134'(req), 134'(0));
          expect_word();
        end else begin
          check("req_hold", 134'(req), 134'(1));
          check("data_wait", ov_data, '0);
        end
      end
      P_SEND: begin
        check("req_send", 134'(req), 134'(0));
        expect_word();
      end
      default: begin
        check("req_gap", 134'(req), 134'(0));
        check("data_gap", ov_data, '0);
        phase = P_IDLE;
      end
    endcase
    check("frame_cnt", 134'(frame_cnt), 134'(m_frames));
    check("drop_pulse", 134'(drop_pulse), 134'(m_drop_now));
    check("drop_cnt", 134'(drop_cnt), 134'(m_drops));
    ack_next = 1'b0;
    if (phase == P_REQ) begin
      if (mux_en) begin
        if (ack_wait == 0) ack_next = 1'b1;
        else ack_wait--;
      end
    end else if (spur) begin
      ack_next = ($urandom_range(3, 0) == 0);
    end
  endtask

  function automatic logic [133:0] mk(input logic [1:0] t, input logic [31:0] p);
    mk = {t, 4'h0, 32'($urandom), 32'($urandom), 32'($urandom), p};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input bit tail_on, input int gap_pct);
    logic [1:0] t;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? 2'b01 : ((i == n - 1 && tail_on) ? 2'b10 : 2'b00);
      step(1'b1, mk(t, base + 32'(i)));
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) step(1'b0, '0);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    data_wr  = 1'b0;
    iv_data  = '0;
    ack      = 1'b0;
    ack_next = 1'b0;
    #1;
    check("rst_req", 134'(req), 134'(0));
    check("rst_data", ov_data, '0);
    check("rst_frame_cnt", 134'(frame_cnt), 134'(0));
    check("rst_drop_pulse", 134'(drop_pulse), 134'(0));
    check("rst_drop_cnt", 134'(drop_cnt), 134'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_data", ov_data, '0);
    check("rst_hold_req", 134'(req), 134'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    phase = P_IDLE;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single 4-word frame, ack one cycle after req
    dly_min = 0; dly_max = 0;
    for (int i = 1; i <= 4; i++)
      step(1'b1, mk((i == 1) ? 2'b01 : ((i == 4) ? 2'b10 : 2'b00), 32'(i)));
    idle(12);

    // Three back-to-back 2-word frames, slow grants
    dly_min = 4; dly_max = 4;
    for (int f = 0; f < 3; f++) send_frame(2, 32'(100 + 10 * f), 1'b1, 0);
    idle(50);

    // Overflow: 129 words parked, next head sees free = 127
    mux_en = 1'b0;
    send_frame(100, 32'h1000, 1'b1, 0);
    send_frame(29, 32'h2000, 1'b1, 0);
    send_frame(4, 32'h3000, 1'b1, 0);
    idle(3);
    mux_en = 1'b1;
    dly_min = 0; dly_max = 2;
    idle(160);
    send_frame(4, 32'h4000, 1'b1, 0);
    idle(15);

    // Head, body, head, body, tail: first partial frame rolled back
    dly_min = 0; dly_max = 0;
    step(1'b1, mk(2'b01, 32'h5000));
    step(1'b1, mk(2'b00, 32'h5001));
    step(1'b1, mk(2'b01, 32'h5100));
    step(1'b1, mk(2'b00, 32'h5101));
    step(1'b1, mk(2'b10, 32'h5102));
    idle(12);

    // Tail commit on the same edge as a tail read
    send_frame(2, 32'h6000, 1'b1, 0);
    send_frame(3, 32'h6100, 1'b1, 0);
    idle(15);

    // Oversized frame dropped, following frame accepted
    send_frame(131, 32'h7000, 1'b1, 0);
    send_frame(2, 32'h7200, 1'b1, 0);
    idle(15);

    // Randomised traffic, well past pointer wrap
    spur = 1'b1; dly_min = 0; dly_max = 5;
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = $urandom_range(99, 0);
      if (sel < 68)       send_frame($urandom_range(12, 2), 32'(k << 8), 1'b1, 20);
      else if (sel < 78)  send_frame($urandom_range(4, 1), 32'(k << 8), 1'b0, 0);
      else if (sel < 84)  step(1'b1, mk(($urandom_range(1, 0) == 0) ? 2'b00 : 2'b10, 32'(k)));
      else if (sel < 88)  send_frame($urandom_range(131, 126), 32'(k << 8), 1'b1, 0);
      else                idle($urandom_range(20, 1));
    end
    send_frame(2, 32'h8000, 1'b1, 0);
    idle(400);

    // Reset while a frame is streaming
    spur = 1'b0; dly_min = 0; dly_max = 0;
    send_frame(10, 32'h9000, 1'b1, 0);
    for (int k = 0; k < 50 && phase != P_SEND; k++) step(1'b0, '0);
    check("reach_send", 134'(phase == P_SEND), 134'(1));
    do_reset();
    idle(10);
    send_frame(3, 32'hA000, 1'b1, 0);
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
